// File: rtl/la_capture_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// la_capture_ctrl_pkg
// Shared declarations for the logic-analyzer capture sequencer:
//   - state_t          : sequencer states (WAIT_LOCK, HOLD_RST, RUN)
//   - DEF_* localparams: default parameter values used by the interface,
//                        the lock synchronizer and the top module
// ----------------------------------------------------------------------------
package la_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD_RST  = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_PRESC_W     = 16;
    localparam int DEF_RST_CYCLES  = 15;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/la_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// la_capture_ctrl_if
// Bundles the sequencer's control and analyzer-side signals.
//   pll_lock  : PLL lock, asynchronous to clk
//   restart   : one-cycle pulse re-running the analyzer reset sequence
//   prescale  : cqual period minus 1 (0 = every cycle)
//   data_in   : bus being sampled by the analyzer
//   la_rst_l  : active-low analyzer reset
//   cqual     : analyzer clock qualifier
//   ready     : high while the analyzer is running
// Modports: slave = the sequencer, master = whoever drives its inputs.
// ----------------------------------------------------------------------------
interface la_capture_ctrl_if
    import la_capture_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PRESC_W = DEF_PRESC_W
);
    logic               pll_lock;
    logic               restart;
    logic [PRESC_W-1:0] prescale;
    logic [DATA_W-1:0]  data_in;
    logic               la_rst_l;
    logic               cqual;
    logic               ready;

    modport slave (
        input  pll_lock, restart, prescale, data_in,
        output la_rst_l, cqual, ready
    );

    modport master (
        output pll_lock, restart, prescale, data_in,
        input  la_rst_l, cqual, ready
    );

endinterface

// File: rtl/la_capture_ctrl_lock_sync.sv
// ----------------------------------------------------------------------------
// lock_sync
// STAGES-deep flop chain bringing an asynchronous level (PLL lock) into the
// clk domain. All flops clear asynchronously to 0, so a reset always reads
// as "not locked" until the input has been seen high for STAGES edges.
//   clk      : destination clock
//   rst      : asynchronous active-high reset
//   async_in : asynchronous level input
//   sync_out : synchronized level (STAGES edges of latency)
// STAGES must be at least 2.
// ----------------------------------------------------------------------------
module lock_sync
    import la_capture_ctrl_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_ff;

    // Shift the raw input through the chain; bit 0 is the metastable stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_ff[STAGES-1];

endmodule

// File: rtl/la_capture_ctrl.sv
// ----------------------------------------------------------------------------
// la_capture_ctrl
// Sequencer between the PLL and the logic-analyzer core. Waits for PLL lock,
// holds the analyzer in reset for RST_CYCLES cycles, then releases it and
// generates the clock-qualifier strobe from a runtime-programmable prescaler.
//   clk  : system clock (PLL global output)
//   rst  : asynchronous active-high reset
//   bus  : la_capture_ctrl_if.slave (pll_lock, restart, prescale, data_in in;
//          la_rst_l, cqual, ready out -- all outputs registered)
// Build option: define LA_CHANGE_QUAL_EN to also assert cqual whenever
// data_in differs from its value on the previous cycle. Without it data_in
// is ignored and the port list is unchanged.
// ----------------------------------------------------------------------------
module la_capture_ctrl
    import la_capture_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int PRESC_W     = DEF_PRESC_W,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    la_capture_ctrl_if.slave   bus
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES - 1);

    logic               lock_s;
    logic               changed;
    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [PRESC_W-1:0] presc_cnt;
    logic [PRESC_W-1:0] presc_lim;
    logic               la_rst_l_q;
    logic               cqual_q;
    logic               ready_q;

    lock_sync #(
        .STAGES   (SYNC_STAGES)
    ) u_lock_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.pll_lock),
        .sync_out (lock_s)
    );

`ifdef LA_CHANGE_QUAL_EN
    logic [DATA_W-1:0] data_q;

    // Previous-cycle copy of the monitored bus, captured unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= bus.data_in;
        end
    end

    assign changed = (bus.data_in != data_q);
`else
    assign changed = 1'b0;
`endif

    // Sequencer. Outputs are set from the state being entered, so they are
    // registered yet line up with the state register. The prescaler limit
    // is only reloaded at RUN entry and at each wrap, so a prescale change
    // never shortens the period already in progress. The RUN entry cycle
    // always strobes and deliberately ignores the change detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            hold_cnt   <= '0;
            presc_cnt  <= '0;
            presc_lim  <= '0;
            la_rst_l_q <= 1'b0;
            cqual_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            la_rst_l_q <= 1'b0;
            ready_q    <= 1'b0;
            cqual_q    <= 1'b0;
            presc_cnt  <= '0;
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state    <= HOLD_RST;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                HOLD_RST: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (bus.restart) begin
                        hold_cnt <= HOLD_LOAD;
                    end else if (hold_cnt == '0) begin
                        state      <= RUN;
                        la_rst_l_q <= 1'b1;
                        ready_q    <= 1'b1;
                        cqual_q    <= 1'b1;
                        presc_lim  <= bus.prescale;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (bus.restart) begin
                        state    <= HOLD_RST;
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        la_rst_l_q <= 1'b1;
                        ready_q    <= 1'b1;
                        if (presc_cnt == presc_lim) begin
                            presc_cnt <= '0;
                            presc_lim <= bus.prescale;
                            cqual_q   <= 1'b1;
                        end else begin
                            presc_cnt <= presc_cnt + 1'b1;
                            cqual_q   <= changed;
                        end
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign bus.la_rst_l = la_rst_l_q;
    assign bus.cqual    = cqual_q;
    assign bus.ready    = ready_q;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_la_capture_ctrl
// Self-checking bench for la_capture_ctrl (RST_CYCLES=8, SYNC_STAGES=2,
// PRESC_W=4 so that prescale=15 exercises the counter wrap boundary).
// A timestamp-based reference model predicts la_rst_l/ready/cqual for every
// cycle; directed sequences pin the model with hand-derived expectations,
// then a randomized phase runs against the model alone.
// ----------------------------------------------------------------------------
module tb_la_capture_ctrl;

    localparam int DW   = 16;
    localparam int PW   = 4;
    localparam int RSTC = 8;
    localparam int SYNC = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    la_capture_ctrl_if #(.DATA_W(DW), .PRESC_W(PW)) bus ();

    la_capture_ctrl #(
        .DATA_W      (DW),
        .PRESC_W     (PW),
        .RST_CYCLES  (RSTC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: mode 0=waiting for lock, 1=holding reset, 2=running.
    int      edgeNum   = 0;
    int      mMode     = 0;
    int      holdEnd   = 0;
    int      nextPulse = 0;
    logic    hist [SYNC];
    logic [DW-1:0] prevData = '0;
    logic    expLaRstL = 1'b0;
    logic    expCqual  = 1'b0;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One model step per clock edge (or on reset). The synchronized lock seen
    // at an edge is pll_lock as it was SYNC edges earlier; hold and prescaler
    // timing are tracked as absolute edge numbers.
    task automatic modelStep();
        logic lockS;
        logic enter;
        logic pulse;
        logic chg;
        if (rst) begin
            mMode     = 0;
            for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
            prevData  = '0;
            expLaRstL = 1'b0;
            expCqual  = 1'b0;
            return;
        end
        edgeNum++;
        lockS = hist[SYNC-1];
        for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.pll_lock;
        enter = 1'b0;
        pulse = 1'b0;
        if (mMode == 0) begin
            if (lockS) begin
                mMode   = 1;
                holdEnd = edgeNum + RSTC;
            end
        end else if (!lockS) begin
            mMode = 0;
        end else if (bus.restart) begin
            mMode   = 1;
            holdEnd = edgeNum + RSTC;
        end else if (mMode == 1 && edgeNum == holdEnd) begin
            mMode = 2;
            enter = 1'b1;
        end else if (mMode == 2 && edgeNum == nextPulse) begin
            pulse = 1'b1;
        end
        if (enter || pulse) nextPulse = edgeNum + int'(bus.prescale) + 1;
`ifdef LA_CHANGE_QUAL_EN
        chg = (mMode == 2) && !enter && (bus.data_in != prevData);
`else
        chg = 1'b0;
`endif
        prevData  = bus.data_in;
        expLaRstL = (mMode == 2);
        expCqual  = (mMode == 2) && (enter || pulse || chg);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            modelStep();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model_la_rst_l", bus.la_rst_l, expLaRstL);
            checkOutput("model_ready",    bus.ready,    expLaRstL);
            checkOutput("model_cqual",    bus.cqual,    expCqual);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic lock, input logic rs, input logic [PW-1:0] presc);
        bus.pll_lock = lock;
        bus.restart  = rs;
        bus.prescale = presc;
    endtask

    // Step to the next edge and wait 1 time unit so outputs have settled.
    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    // Lock (or reset release) is sampled at k=0; la_rst_l rises 2+8 edges later.
    task automatic checkBringUp(input string name);
        for (int k = 0; k < 12; k++) begin
            nextEdge();
            checkOutput(name, bus.la_rst_l, (k >= SYNC + RSTC));
        end
    endtask

    initial begin
        logic found;
        rst         = 1'b1;
        bus.data_in = '0;
        applyStimulus(1'b0, 1'b0, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_la_rst_l", bus.la_rst_l, 1'b0);
        checkOutput("reset_cqual",    bus.cqual,    1'b0);
        checkOutput("reset_ready",    bus.ready,    1'b0);
        rst = 1'b0;
        repeat (4) nextEdge();

        // Lock bring-up with prescale 3: strobes at RUN+0, +4, ...
        bus.pll_lock = 1'b1;
        for (int k = 0; k < 14; k++) begin
            nextEdge();
            checkOutput("bringup_la_rst_l", bus.la_rst_l, (k >= 10));
            checkOutput("bringup_cqual",    bus.cqual,    (k >= 10) && ((k - 10) % 4 == 0));
        end

        // Restart in RUN: la_rst_l low for exactly 8 cycles, strobe on re-entry.
        bus.restart = 1'b1;
        for (int k = 0; k < 10; k++) begin
            nextEdge();
            bus.restart = 1'b0;
            checkOutput("restart_la_rst_l", bus.la_rst_l, (k >= 8));
            checkOutput("restart_cqual",    bus.cqual,    (k == 8));
        end

        // prescale 0 -> strobe every cycle once the current period wraps.
        bus.prescale = 4'd0;
        repeat (4) nextEdge();
        for (int k = 0; k < 6; k++) begin
            nextEdge();
            checkOutput("presc0_cqual", bus.cqual, 1'b1);
        end

        // prescale 5 -> strobes exactly 6 apart from the next wrap on.
        bus.prescale = 4'd5;
        for (int k = 0; k < 13; k++) begin
            nextEdge();
            checkOutput("presc5_cqual", bus.cqual, (k % 6 == 0));
        end

        // All-ones prescale: period 16 across the counter wrap.
        bus.prescale = 4'd15;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            nextEdge();
            found = bus.cqual;
        end
        checkOutput("wrap_first_pulse", found, 1'b1);
        for (int k = 1; k <= 32; k++) begin
            nextEdge();
            checkOutput("wrap_cqual", bus.cqual, (k % 16 == 0));
        end

        // Lock loss coinciding with restart: lock loss wins, stays in reset.
        bus.pll_lock = 1'b0;
        for (int k = 0; k < 14; k++) begin
            nextEdge();
            bus.restart = (k == 1);
            checkOutput("lockloss_la_rst_l", bus.la_rst_l, (k < 2));
        end
        bus.restart  = 1'b0;
        bus.pll_lock = 1'b1;
        checkBringUp("relock_la_rst_l");

        // Asynchronous reset while running drops outputs without a clock edge.
        nextEdge();
        rst = 1'b1;
        #1;
        checkOutput("async_run_la_rst_l", bus.la_rst_l, 1'b0);
        checkOutput("async_run_ready",    bus.ready,    1'b0);
        nextEdge();
        rst = 1'b0;
        checkBringUp("async_run_rebringup");

        // Asynchronous reset in the middle of the hold period.
        nextEdge();
        bus.restart = 1'b1;
        nextEdge();
        bus.restart = 1'b0;
        repeat (3) nextEdge();
        rst = 1'b1;
        #1;
        checkOutput("async_hold_la_rst_l", bus.la_rst_l, 1'b0);
        checkOutput("async_hold_cqual",    bus.cqual,    1'b0);
        nextEdge();
        rst = 1'b0;
        checkBringUp("async_hold_rebringup");

`ifdef LA_CHANGE_QUAL_EN
        // Change strobe: RUN+0 (entry, no change strobe), RUN+7 (data change), RUN+16 (tick).
        bus.restart = 1'b1;
        for (int k = 0; k < 26; k++) begin
            nextEdge();
            bus.restart = 1'b0;
            if (k == 14) bus.data_in = 16'h00A5;
            if (k >= 8) begin
                checkOutput("change_cqual", bus.cqual,
                            (k - 8 == 0) || (k - 8 == 7) || (k - 8 == 16));
            end
        end
`endif

        // Randomized phase, checked by the model only.
        for (int c = 0; c < 3000; c++) begin
            nextEdge();
            if (bus.pll_lock) begin
                if ($urandom_range(0, 199) == 0) bus.pll_lock = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                bus.pll_lock = 1'b1;
            end
            bus.restart = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 24) == 0) bus.prescale = PW'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0)  bus.data_in  = DW'($urandom);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 799) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        repeat (3) nextEdge();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
